sw_event_sequencer: RTL and testbench
=====================================

// Module: sw_event_sequencer
// PURPOSE
//  Avalon-MM master servicing the switch PIO (edge-capture, irq_mask, data regs).
//  Programs irq_mask, sequences interrupt service (read/clear edge_capture, read level).
//  Delivers timestamped switch events to fabric consumers over valid/ready via small FIFO.
//  Removes the HPS from the switch-interrupt path.
// PARAMETERS
//  WIDTH       10       switch count; matches PIO in_port width
//  FIFO_DEPTH  8        event FIFO entries; power of 2, >=2
//  MASK_INIT   10'h3FF  irq_mask written after reset
// PORTS
//  clk            in   1      clock
//  reset_n        in   1      asynchronous, active-low reset
//  enable         in   1      1 = service irq; 0 = finish current sequence, then idle
//  cfg_mask       in   WIDTH  new irq_mask value
//  cfg_mask_wr    in   1      1-cycle pulse: latch cfg_mask, write at next IDLE
//  pio_address    out  2      PIO register address (0 data, 2 irq_mask, 3 edge_capture)
//  pio_chipselect out  1      PIO chipselect
//  pio_write_n    out  1      PIO write strobe, active low
//  pio_writedata  out  32     PIO write data; WIDTH LSBs used, rest 0
//  pio_readdata   in   32     PIO read data; registered, valid the cycle after address
//  pio_irq        in   1      PIO interrupt, level
//  evt_valid      out  1      event available
//  evt_ready      in   1      consumer accepts when evt_valid&evt_ready
//  evt_edges      out  WIDTH  edge_capture bits serviced
//  evt_level      out  WIDTH  switch levels read after clear
//  evt_time       out  16     timestamp counter at capture read
//  busy           out  1      FSM not in IDLE
//  ovf            out  1      sticky: event dropped on full FIFO; cleared only by reset
//  drop_cnt       out  8      dropped events; saturates at 255
// BEHAVIOUR
//  Reset: outputs 0, except pio_write_n=1. FIFO empty, timestamp 0, mask pending 0.
//  After reset, FSM enters INIT_MASK.
//  Bus cycle: chipselect high exactly one cycle per access; read/write idle otherwise.
//   Read data sampled the following cycle (fixed latency 1).
//  States:
//   INIT_MASK: write MASK_INIT to addr 2 -> IDLE.
//   IDLE: priority order:
//    1. mask pending -> WR_MASK.
//    2. enable & pio_irq -> RD_CAP.
//    3. else stay.
//   WR_MASK: write latched cfg_mask to addr 2, clear pending -> IDLE.
//   RD_CAP: read addr 3 -> WAIT_CAP.
//   WAIT_CAP: edges<=readdata[WIDTH-1:0], time<=counter.
//    If edges==0 (spurious) -> IDLE, no write, no event; else -> CLR_CAP.
//   CLR_CAP: write edges to addr 3 (W1C). Clears only the serviced bits;
//    edges arriving meanwhile stay captured and re-raise irq -> RD_DAT.
//   RD_DAT: read addr 0 -> WAIT_DAT.
//   WAIT_DAT: level<=readdata -> PUSH.
//   PUSH: FIFO write {time,edges,level}; if full, drop, ovf<=1, drop_cnt+1 (sat) -> IDLE.
//  Latency: irq seen in IDLE at cycle t -> chipselect addr3 at t+1 -> clear write at t+3
//   -> evt_valid at t+7 (FIFO empty, no pending mask).
//  cfg_mask_wr in any state: latched; a later pulse overwrites the pending value.
//   Serviced from IDLE before irq.
//  FIFO: show-ahead, evt_* valid while evt_valid.
//   Simultaneous push and pop when full: pop frees a slot; push accepted, no drop.
//  Timestamp: free-running 16-bit counter, wraps 0xFFFF->0.
//  enable deassert mid-sequence: sequence completes; FSM then holds in IDLE.
//  Reset mid-sequence: immediate async abort. Bus returns idle, FIFO flushed, INIT_MASK reruns.
// STRUCTURE
//  Package sw_evt_pkg: PIO register address constants (DATA=0, MASK=2, EDGE=3), FSM state enum.
//  Sub-module sw_evt_fifo: sync FIFO, params WIDTH/DEPTH, full/empty, show-ahead output.
//  FSM, bus driver, timestamp and drop counters live in the top module.
// TESTING
//  1. Reset release -> one write addr2 data 0x3FF; then busy=0, no further bus activity.
//  2. PIO model edge_capture=0x008, level=0x008, irq=1 -> read3, write3 0x008, read0;
//     evt_edges=0x008, evt_level=0x008, evt_valid 7 cycles after IDLE irq.
//  3. irq=1, readdata addr3=0 -> no write, no event, back to IDLE 3 cycles later.
//  4. evt_ready=0, 9 events, DEPTH 8 -> 8 queued, ovf=1, drop_cnt=1; pop all -> order preserved.
//  5. cfg_mask_wr 0x00F during CLR_CAP -> sequence completes, then write addr2 0x00F before next irq.
//  6. reset_n low in RD_DAT -> chipselect 0 same cycle, FIFO empty, INIT_MASK write after release.

Source files
------------

// File: rtl/sw_evt_pkg.sv
// Shared constants for the switch event sequencer: PIO register map and FSM states.
package sw_evt_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    // ST_RESET holds the bus idle for the first clock after reset release.
    typedef enum logic [3:0] {
        ST_RESET,
        ST_INIT_MASK,
        ST_IDLE,
        ST_WR_MASK,
        ST_RD_CAP,
        ST_WAIT_CAP,
        ST_CLR_CAP,
        ST_RD_DAT,
        ST_WAIT_DAT,
        ST_PUSH
    } state_e;

endpackage

// File: rtl/sw_evt_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted when a pop frees a slot.
module sw_evt_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push;
    logic             pop;

    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop     = rd_en && !empty;
    assign push    = wr_en && (!full || pop);
    assign rd_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sw_event_sequencer.sv
// Avalon-MM master that services the switch PIO interrupt and queues timestamped events.
module sw_event_sequencer
    import sw_evt_pkg::*;
#(
    parameter int               WIDTH      = 10,
    parameter int               FIFO_DEPTH = 8,
    parameter logic [WIDTH-1:0] MASK_INIT  = 10'h3FF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] cfg_mask,
    input  logic             cfg_mask_wr,
    output logic [1:0]       pio_address,
    output logic             pio_chipselect,
    output logic             pio_write_n,
    output logic [31:0]      pio_writedata,
    input  logic [31:0]      pio_readdata,
    input  logic             pio_irq,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_edges,
    output logic [WIDTH-1:0] evt_level,
    output logic [15:0]      evt_time,
    output logic             busy,
    output logic             ovf,
    output logic [7:0]       drop_cnt,
    output logic [3:0]       dbg_state
);
    localparam int EW = 16 + 2 * WIDTH;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mask_q, edges_q, level_q;
    logic             mask_pend_q, ovf_q;
    logic [15:0]      time_q, ts_q;
    logic [7:0]       drop_q;
    logic             fifo_wr, fifo_pop, fifo_full, fifo_empty;
    logic [EW-1:0]    fifo_rdata;
    logic             unused_rd;

    assign unused_rd = ^pio_readdata[31:WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_RESET;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:     state_d = ST_INIT_MASK;
            ST_INIT_MASK: state_d = ST_IDLE;
            ST_IDLE: begin
                if (mask_pend_q)           state_d = ST_WR_MASK;
                else if (enable && pio_irq) state_d = ST_RD_CAP;
            end
            ST_WR_MASK:   state_d = ST_IDLE;
            ST_RD_CAP:    state_d = ST_WAIT_CAP;
            // An empty capture register means a spurious interrupt: nothing to clear or report.
            ST_WAIT_CAP:  state_d = (pio_readdata[WIDTH-1:0] == '0) ? ST_IDLE : ST_CLR_CAP;
            ST_CLR_CAP:   state_d = ST_RD_DAT;
            ST_RD_DAT:    state_d = ST_WAIT_DAT;
            ST_WAIT_DAT:  state_d = ST_PUSH;
            ST_PUSH:      state_d = ST_IDLE;
            default:      state_d = ST_RESET;
        endcase
    end

    always_comb begin
        pio_chipselect = 1'b0;
        pio_write_n    = 1'b1;
        pio_address    = ADDR_DATA;
        pio_writedata  = '0;
        fifo_wr        = 1'b0;
        case (state_q)
            ST_INIT_MASK: begin
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                pio_address    = ADDR_MASK;
                pio_writedata  = 32'(MASK_INIT);
            end
            ST_WR_MASK: begin
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                pio_address    = ADDR_MASK;
                pio_writedata  = 32'(mask_q);
            end
            ST_RD_CAP: begin
                pio_chipselect = 1'b1;
                pio_address    = ADDR_EDGE;
            end
            ST_CLR_CAP: begin
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                pio_address    = ADDR_EDGE;
                pio_writedata  = 32'(edges_q);
            end
            ST_RD_DAT: begin
                pio_chipselect = 1'b1;
                pio_address    = ADDR_DATA;
            end
            ST_PUSH:  fifo_wr = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q      <= '0;
            mask_pend_q <= 1'b0;
            edges_q     <= '0;
            level_q     <= '0;
            time_q      <= '0;
            ts_q        <= '0;
            ovf_q       <= 1'b0;
            drop_q      <= '0;
        end else begin
            ts_q <= ts_q + 16'd1;
            // A new request arriving during WR_MASK keeps the pending flag for the newer value.
            if (cfg_mask_wr) begin
                mask_q      <= cfg_mask;
                mask_pend_q <= 1'b1;
            end else if (state_q == ST_WR_MASK) begin
                mask_pend_q <= 1'b0;
            end
            if (state_q == ST_WAIT_CAP) begin
                edges_q <= pio_readdata[WIDTH-1:0];
                time_q  <= ts_q;
            end
            if (state_q == ST_WAIT_DAT) level_q <= pio_readdata[WIDTH-1:0];
            if (fifo_wr && fifo_full && !fifo_pop) begin
                ovf_q <= 1'b1;
                if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            end
        end
    end

    sw_evt_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (fifo_wr),
        .wr_data ({time_q, edges_q, level_q}),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign evt_valid = !fifo_empty;
    assign fifo_pop  = evt_valid && evt_ready;
    assign evt_time  = evt_valid ? fifo_rdata[EW-1 -: 16] : '0;
    assign evt_edges = evt_valid ? fifo_rdata[2*WIDTH-1 -: WIDTH] : '0;
    assign evt_level = evt_valid ? fifo_rdata[WIDTH-1:0] : '0;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_RESET);
    assign ovf       = ovf_q;
    assign drop_cnt  = drop_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sw_event_sequencer.sv
// Scoreboard bench: PIO register model, bus-transaction queue and event queue for the sequencer.
module tb_sw_event_sequencer;
    import sw_evt_pkg::*;

    localparam int W = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b1;
    logic [W-1:0]  cfg_mask = '0;
    logic          cfg_mask_wr = 1'b0;
    logic [1:0]    pio_address;
    logic          pio_chipselect, pio_write_n;
    logic [31:0]   pio_writedata;
    logic [31:0]   pio_readdata = '0;
    logic          pio_irq;
    logic          evt_valid;
    logic          evt_ready = 1'b0;
    logic [W-1:0]  evt_edges, evt_level;
    logic [15:0]   evt_time;
    logic          busy, ovf;
    logic [7:0]    drop_cnt;
    logic [3:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    logic [34:0] exp_bus_q[$];
    logic [35:0] exp_evt_q[$];
    logic [15:0] cap_time_q[$];

    sw_event_sequencer dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .cfg_mask(cfg_mask),
        .cfg_mask_wr(cfg_mask_wr), .pio_address(pio_address), .pio_chipselect(pio_chipselect),
        .pio_write_n(pio_write_n), .pio_writedata(pio_writedata), .pio_readdata(pio_readdata),
        .pio_irq(pio_irq), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_edges(evt_edges),
        .evt_level(evt_level), .evt_time(evt_time), .busy(busy), .ovf(ovf),
        .drop_cnt(drop_cnt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // PIO model: registered read data, W1C edge capture, irq = any unmasked captured edge.
    logic [W-1:0] edge_cap = '0;
    logic [W-1:0] mask_reg = '0;
    logic [W-1:0] level = '0;
    logic [W-1:0] inj = '0;
    logic         force_irq = 1'b0;
    logic [W-1:0] clr;
    assign clr     = (pio_chipselect && !pio_write_n && pio_address == ADDR_EDGE) ? pio_writedata[W-1:0] : '0;
    assign pio_irq = force_irq | (|(edge_cap & mask_reg));

    always @(posedge clk) begin
        if (pio_chipselect && pio_write_n) begin
            case (pio_address)
                ADDR_DATA: pio_readdata <= 32'(level);
                ADDR_MASK: pio_readdata <= 32'(mask_reg);
                ADDR_EDGE: pio_readdata <= 32'(edge_cap);
                default:   pio_readdata <= '0;
            endcase
        end
        if (pio_chipselect && !pio_write_n && pio_address == ADDR_MASK) mask_reg <= pio_writedata[W-1:0];
        edge_cap <= (edge_cap & ~clr) | inj;
    end

    logic [15:0] tb_cnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tb_cnt <= '0;
        else          tb_cnt <= tb_cnt + 16'd1;
    end

    // Bus monitor: every chipselect cycle must match the head of the expected transaction queue.
    logic [34:0] bus_got, bus_exp;
    always @(negedge clk) begin
        if (reset_n && pio_chipselect) begin
            bus_got = {~pio_write_n, pio_address, pio_write_n ? 32'h0 : pio_writedata};
            if (pio_write_n && pio_address == ADDR_EDGE) cap_time_q.push_back(tb_cnt + 16'd1);
            checks++;
            if (exp_bus_q.size() == 0) begin
                errors++;
                $display("FAIL bus_unexpected got=%h required=none", bus_got);
            end else begin
                bus_exp = exp_bus_q.pop_front();
                if (bus_got !== bus_exp) begin
                    errors++;
                    $display("FAIL bus_txn got=%h required=%h", bus_got, bus_exp);
                end
            end
        end
    end

    task automatic push_seq_exp(input logic [W-1:0] e);
        exp_bus_q.push_back({1'b0, ADDR_EDGE, 32'h0});
        exp_bus_q.push_back({1'b1, ADDR_EDGE, 32'(e)});
        exp_bus_q.push_back({1'b0, ADDR_DATA, 32'h0});
    endtask

    task automatic push_evt(input logic [W-1:0] e, input logic [W-1:0] l);
        logic [15:0] t;
        t = (cap_time_q.size() != 0) ? cap_time_q.pop_front() : 16'h0;
        exp_evt_q.push_back({t, e, l});
    endtask

    task automatic inject(input logic [W-1:0] e);
        @(negedge clk) inj = e;
        @(negedge clk) inj = '0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout busy=%b required=0", name, busy);
        end
    endtask

    task automatic bus_drained(input string name);
        checks++;
        if (exp_bus_q.size() != 0) begin
            errors++;
            $display("FAIL %s_bus_missing pending=%0d required=0", name, exp_bus_q.size());
            exp_bus_q.delete();
        end
    endtask

    task automatic pop_all(input string name);
        int n = 0;
        logic [35:0] e;
        evt_ready = 1'b1;
        while (exp_evt_q.size() != 0 && n < 64) begin
            if (evt_valid) begin
                e = exp_evt_q.pop_front();
                checks++;
                if ({evt_time, evt_edges, evt_level} !== e) begin
                    errors++;
                    $display("FAIL %s_evt got=%h required=%h", name, {evt_time, evt_edges, evt_level}, e);
                end
            end
            @(negedge clk);
            n++;
        end
        evt_ready = 1'b0;
        checks++;
        if (exp_evt_q.size() != 0 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain left=%0d evt_valid=%b required=0/0", name, exp_evt_q.size(), evt_valid);
            exp_evt_q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({pio_chipselect, pio_write_n, busy, evt_valid, ovf} !== 5'b01000) begin
            errors++;
            $display("FAIL reset_ctrl got=%b required=01000", {pio_chipselect, pio_write_n, busy, evt_valid, ovf});
        end
        checks++;
        if ({drop_cnt, pio_address, pio_writedata} !== 42'h0) begin
            errors++;
            $display("FAIL reset_data got=%h required=0", {drop_cnt, pio_address, pio_writedata});
        end
        exp_bus_q.push_back({1'b1, ADDR_MASK, 32'h3FF});
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        bus_drained("reset");
        checks++;
        if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_idle busy=%b state=%0d required=0/%0d", busy, dbg_state, ST_IDLE);
        end
    endtask

    task automatic test_single_event();
        int n = 0;
        level = 10'h008;
        push_seq_exp(10'h008);
        inject(10'h008);
        while (!evt_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 7) begin
            errors++;
            $display("FAIL single_latency got=%0d required=7", n);
        end
        checks++;
        if (evt_edges !== 10'h008 || evt_level !== 10'h008) begin
            errors++;
            $display("FAIL single_fields edges=%h level=%h required=008/008", evt_edges, evt_level);
        end
        bus_drained("single");
        push_evt(10'h008, 10'h008);
        pop_all("single");
    endtask

    task automatic test_spurious_and_enable();
        @(negedge clk) force_irq = 1'b1;
        exp_bus_q.push_back({1'b0, ADDR_EDGE, 32'h0});
        @(negedge clk) force_irq = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL spurious_wait busy=%b required=1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL spurious_idle busy=%b evt_valid=%b required=0/0", busy, evt_valid);
        end
        repeat (3) @(negedge clk);
        bus_drained("spurious");
        cap_time_q.delete();
        enable = 1'b0;
        level = 10'h1A5;
        inject(10'h040);
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL disabled_busy got=%b required=0", busy);
        end
        push_seq_exp(10'h040);
        enable = 1'b1;
        wait_idle("enable");
        bus_drained("enable");
        push_evt(10'h040, 10'h1A5);
        pop_all("enable");
    endtask

    task automatic test_overflow();
        logic [W-1:0] e, l;
        for (int i = 0; i < 9; i++) begin
            e = 10'd1 << $urandom_range(0, 9);
            l = 10'($urandom_range(0, 1023));
            level = l;
            push_seq_exp(e);
            inject(e);
            wait_idle("ovf");
            if (i < 8) push_evt(e, l);
            else if (cap_time_q.size() != 0) void'(cap_time_q.pop_front());
            if (i == 7) begin
                checks++;
                if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin
                    errors++;
                    $display("FAIL full_no_drop ovf=%b drop=%0d required=0/0", ovf, drop_cnt);
                end
            end
        end
        bus_drained("ovf");
        checks++;
        if (ovf !== 1'b1 || drop_cnt !== 8'd1 || evt_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flags ovf=%b drop=%0d valid=%b required=1/1/1", ovf, drop_cnt, evt_valid);
        end
        pop_all("ovf");
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got=%b required=1", ovf);
        end
    endtask

    task automatic test_mask_update();
        level = 10'h155;
        push_seq_exp(10'h004);
        exp_bus_q.push_back({1'b1, ADDR_MASK, 32'h00F});
        push_seq_exp(10'h002);
        inject(10'h004);
        repeat (3) @(negedge clk);
        checks++;
        if (dbg_state !== ST_CLR_CAP) begin
            errors++;
            $display("FAIL mask_state got=%0d required=%0d", dbg_state, ST_CLR_CAP);
        end
        cfg_mask = 10'h00F;
        cfg_mask_wr = 1'b1;
        inj = 10'h002;
        @(negedge clk);
        cfg_mask_wr = 1'b0;
        inj = '0;
        repeat (25) @(negedge clk);
        bus_drained("mask");
        checks++;
        if (busy !== 1'b0 || mask_reg !== 10'h00F) begin
            errors++;
            $display("FAIL mask_final busy=%b mask=%h required=0/00F", busy, mask_reg);
        end
        push_evt(10'h004, 10'h155);
        push_evt(10'h002, 10'h155);
        pop_all("mask");
    endtask

    task automatic test_reset_abort();
        level = 10'h2AA;
        push_seq_exp(10'h001);
        inject(10'h001);
        wait_idle("abort_pre");
        push_seq_exp(10'h008);
        inject(10'h008);
        repeat (4) @(negedge clk);
        checks++;
        if (dbg_state !== ST_RD_DAT || pio_chipselect !== 1'b1 || evt_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup state=%0d cs=%b valid=%b required=%0d/1/1", dbg_state, pio_chipselect, evt_valid, ST_RD_DAT);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({pio_chipselect, pio_write_n, evt_valid, busy} !== 4'b0100) begin
            errors++;
            $display("FAIL abort_outputs got=%b required=0100", {pio_chipselect, pio_write_n, evt_valid, busy});
        end
        bus_drained("abort");
        exp_evt_q.delete();
        cap_time_q.delete();
        exp_bus_q.push_back({1'b1, ADDR_MASK, 32'h3FF});
        @(negedge clk) reset_n = 1'b1;
        repeat (10) @(negedge clk);
        bus_drained("abort_init");
        checks++;
        if (busy !== 1'b0 || evt_valid !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL abort_after busy=%b valid=%b ovf=%b required=0/0/0", busy, evt_valid, ovf);
        end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_spurious_and_enable();
        test_overflow();
        test_mask_update();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
